leitor_operandos_rpn: RTL and testbench

Operand-fetch controller for the 8-bit RPN ALU: on an operation request it reads the top one or two entries of the operand stack through the stack's read port and latches them as ALU operands. It presents them with a valid/ready handshake and, on acceptance, issues a pop command back to the stack write side. It is the read end of the stack; the enable-loaded stack registers are the write end.

---
 rtl/leitor_operandos_rpn_pkg.sv | 23 ++
 rtl/registrador_habilitado.sv | 20 ++
 rtl/leitor_operandos_rpn.sv | 142 ++++++++++++++
 tb/tb_leitor_operandos_rpn.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/leitor_operandos_rpn_pkg.sv
// Shared types and constants for the RPN operand-fetch controller.
package leitor_operandos_rpn_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_TOP  = 2'd1,
    READ_NEXT = 2'd2,
    PRESENT   = 2'd3
  } state_t;

  localparam logic [1:0] POP_N_NONE = 2'd0;
  localparam logic [1:0] POP_N_ONE  = 2'd1;
  localparam logic [1:0] POP_N_TWO  = 2'd2;

  // Number of stack entries an operation consumes.
  function automatic logic [1:0] need_of(input logic unary);
    return unary ? POP_N_ONE : POP_N_TWO;
  endfunction

endpackage

// File: rtl/registrador_habilitado.sv
// WIDTH-bit register with load enable and synchronous clear (clear wins).
module registrador_habilitado #(
  parameter int WIDTH = 8
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear has priority over load; otherwise hold.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/leitor_operandos_rpn.sv
// Operand-fetch controller: reads top one/two stack entries, presents them
// to the ALU with valid/ready, and pops the stack on acceptance.
//
// state     | meaning
// ----------|--------------------------------------------------
// IDLE      | waiting for START; rejects with UNDERFLOW if short
// READ_TOP  | RD_ADDR = count-1; latch top entry (OP_B, or OP_A if unary)
// READ_NEXT | RD_ADDR = count-2; latch deeper entry into OP_A
// PRESENT   | VALID high; POP issued in the cycle READY is seen
module leitor_operandos_rpn
  import leitor_operandos_rpn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = 2
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic             UNARY,
  input  logic [PTR_W:0]   COUNT,
  output logic [PTR_W-1:0] RD_ADDR,
  input  logic [WIDTH-1:0] RD_DATA,
  output logic [WIDTH-1:0] OP_A,
  output logic [WIDTH-1:0] OP_B,
  output logic             VALID,
  input  logic             READY,
  output logic             POP,
  output logic [1:0]       POP_N,
  output logic             BUSY,
  output logic             UNDERFLOW
);

  state_t           state_q, state_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             un_q, un_d;
  logic [PTR_W-1:0] rd_addr_q, rd_addr_d;
  logic             underflow_q, underflow_d;
  logic             valid_q, busy_q;
  logic             ld_a, ld_b, clr_b;
  logic             pop;
  logic [PTR_W:0]   need_in;

  assign need_in = (PTR_W+1)'(need_of(UNARY));

  // State and registered outputs; RD_ADDR is set one edge ahead so it is
  // valid throughout the read state that uses it.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      un_q        <= 1'b0;
      rd_addr_q   <= '0;
      underflow_q <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      un_q        <= un_d;
      rd_addr_q   <= rd_addr_d;
      underflow_q <= underflow_d;
      valid_q     <= (state_d == PRESENT);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Next-state, read address, operand load strobes and pop decision.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    un_d        = un_q;
    rd_addr_d   = '0;
    underflow_d = 1'b0;
    ld_a        = 1'b0;
    ld_b        = 1'b0;
    clr_b       = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          cnt_d = COUNT;
          un_d  = UNARY;
          if (COUNT < need_in) begin
            underflow_d = 1'b1;
          end else begin
            state_d   = READ_TOP;
            rd_addr_d = PTR_W'(COUNT - (PTR_W+1)'(1));
          end
        end
      end
      READ_TOP: begin
        if (un_q) begin
          ld_a    = 1'b1;
          clr_b   = 1'b1;
          state_d = PRESENT;
        end else begin
          ld_b      = 1'b1;
          state_d   = READ_NEXT;
          rd_addr_d = PTR_W'(cnt_q - (PTR_W+1)'(2));
        end
      end
      READ_NEXT: begin
        ld_a    = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (READY) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  registrador_habilitado #(.WIDTH(WIDTH)) u_reg_a (
    .clk_sys (CLOCK),
    .rst_n   (RESET),
    .en      (ld_a),
    .clr     (1'b0),
    .d       (RD_DATA),
    .q       (OP_A)
  );

  registrador_habilitado #(.WIDTH(WIDTH)) u_reg_b (
    .clk_sys (CLOCK),
    .rst_n   (RESET),
    .en      (ld_b),
    .clr     (clr_b),
    .d       (RD_DATA),
    .q       (OP_B)
  );

  assign RD_ADDR   = rd_addr_q;
  assign VALID     = valid_q;
  assign BUSY      = busy_q;
  assign UNDERFLOW = underflow_q;
  assign POP       = pop;
  assign POP_N     = pop ? need_of(un_q) : POP_N_NONE;

endmodule

// File: tb/tb_leitor_operandos_rpn.sv
module tb_leitor_operandos_rpn;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic       UNARY = 1'b0;
  logic [2:0] COUNT = '0;
  logic [1:0] RD_ADDR;
  logic [7:0] RD_DATA;
  logic [7:0] OP_A, OP_B;
  logic       VALID, READY = 1'b0, POP, BUSY, UNDERFLOW;
  logic [1:0] POP_N;
  logic [7:0] mem [4];

  int checks = 0;
  int errors = 0;

  assign RD_DATA = mem[RD_ADDR];

  always #5 CLOCK = ~CLOCK;

  leitor_operandos_rpn #(.WIDTH(8), .DEPTH(4), .PTR_W(2)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .UNARY(UNARY), .COUNT(COUNT),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .OP_A(OP_A), .OP_B(OP_B),
    .VALID(VALID), .READY(READY), .POP(POP), .POP_N(POP_N), .BUSY(BUSY),
    .UNDERFLOW(UNDERFLOW)
  );

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    #2;
    checks++;
    if ({OP_A, OP_B, RD_ADDR, VALID, POP, POP_N, BUSY, UNDERFLOW} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h b=%h addr=%0d v=%b pop=%b pn=%0d busy=%b uf=%b expected all 0",
               OP_A, OP_B, RD_ADDR, VALID, POP, POP_N, BUSY, UNDERFLOW);
    end
    step();
    RESET = 1'b1;
    step();
  endtask

  task automatic test_binary();
    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'hEE;
    COUNT = 3'd3; UNARY = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || VALID !== 1'b0 || RD_ADDR !== 2'd2) begin
      errors++;
      $display("FAIL bin_read_top: busy=%b valid=%b addr=%0d expected 1 0 2", BUSY, VALID, RD_ADDR);
    end
    step();
    checks++;
    if (RD_ADDR !== 2'd1 || OP_B !== 8'd30 || VALID !== 1'b0) begin
      errors++;
      $display("FAIL bin_read_next: addr=%0d b=%0d valid=%b expected 1 30 0", RD_ADDR, OP_B, VALID);
    end
    step();
    checks++;
    if (VALID !== 1'b1 || OP_A !== 8'd20 || OP_B !== 8'd30 || RD_ADDR !== 2'd0 || POP !== 1'b0) begin
      errors++;
      $display("FAIL bin_present: valid=%b a=%0d b=%0d addr=%0d pop=%b expected 1 20 30 0 0",
               VALID, OP_A, OP_B, RD_ADDR, POP);
    end
    READY = 1'b1;
    #1;
    checks++;
    if (POP !== 1'b1 || POP_N !== 2'd2) begin
      errors++;
      $display("FAIL bin_pop: pop=%b pop_n=%0d expected 1 2", POP, POP_N);
    end
    step();
    READY = 1'b0;
    checks++;
    if (VALID !== 1'b0 || BUSY !== 1'b0 || POP !== 1'b0) begin
      errors++;
      $display("FAIL bin_after: valid=%b busy=%b pop=%b expected 0 0 0", VALID, BUSY, POP);
    end
  endtask

  task automatic test_unary();
    mem[0] = 8'h7F;
    COUNT = 3'd1; UNARY = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    checks++;
    if (VALID !== 1'b0 || RD_ADDR !== 2'd0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL un_read_top: valid=%b addr=%0d busy=%b expected 0 0 1", VALID, RD_ADDR, BUSY);
    end
    step();
    checks++;
    if (VALID !== 1'b1 || OP_A !== 8'h7F || OP_B !== 8'h00) begin
      errors++;
      $display("FAIL un_present: valid=%b a=%h b=%h expected 1 7f 00", VALID, OP_A, OP_B);
    end
    READY = 1'b1;
    #1;
    checks++;
    if (POP !== 1'b1 || POP_N !== 2'd1) begin
      errors++;
      $display("FAIL un_pop: pop=%b pop_n=%0d expected 1 1", POP, POP_N);
    end
    step();
    READY = 1'b0;
  endtask

  task automatic test_underflow();
    // Binary with one entry, then unary with an empty stack.
    for (int k = 0; k < 2; k++) begin
      COUNT = (k == 0) ? 3'd1 : 3'd0;
      UNARY = (k == 0) ? 1'b0 : 1'b1;
      START = 1'b1;
      step();
      START = 1'b0;
      checks++;
      if (UNDERFLOW !== 1'b1 || BUSY !== 1'b0 || VALID !== 1'b0) begin
        errors++;
        $display("FAIL underflow_pulse[%0d]: uf=%b busy=%b valid=%b expected 1 0 0", k, UNDERFLOW, BUSY, VALID);
      end
      step();
      checks++;
      if (UNDERFLOW !== 1'b0 || BUSY !== 1'b0 || VALID !== 1'b0 || POP !== 1'b0 || OP_A !== 8'h7F) begin
        errors++;
        $display("FAIL underflow_after[%0d]: uf=%b busy=%b valid=%b pop=%b a=%h expected 0 0 0 0 7f",
                 k, UNDERFLOW, BUSY, VALID, POP, OP_A);
      end
    end
  endtask

  task automatic test_hold();
    int pops;
    pops = 0;
    mem[0] = 8'h11; mem[1] = 8'h22;
    COUNT = 3'd2; UNARY = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      COUNT = 3'(i);
      mem[0] = 8'(8'hA0 + i); mem[1] = 8'(8'hB0 + i);
      if (POP === 1'b1) pops++;
      checks++;
      if (VALID !== 1'b1 || OP_A !== 8'h11 || OP_B !== 8'h22) begin
        errors++;
        $display("FAIL hold[%0d]: valid=%b a=%h b=%h expected 1 11 22", i, VALID, OP_A, OP_B);
      end
      step();
    end
    READY = 1'b1;
    #1;
    if (POP === 1'b1) pops++;
    step();
    READY = 1'b0;
    if (POP === 1'b1) pops++;
    checks++;
    if (pops !== 1 || VALID !== 1'b0) begin
      errors++;
      $display("FAIL hold_single_pop: pops=%0d valid=%b expected 1 0", pops, VALID);
    end
  endtask

  task automatic test_reset_mid();
    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30;
    COUNT = 3'd3; UNARY = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    step();
    READY = 1'b1;
    RESET = 1'b0;
    #1;
    checks++;
    if ({OP_A, OP_B, RD_ADDR, VALID, POP, POP_N, BUSY, UNDERFLOW} !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid: a=%h b=%h addr=%0d v=%b pop=%b pn=%0d busy=%b expected all 0",
               OP_A, OP_B, RD_ADDR, VALID, POP, POP_N, BUSY);
    end
    step();
    RESET = 1'b1;
    READY = 1'b0;
    mem[0] = 8'h5A;
    COUNT = 3'd1; UNARY = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    step();
    checks++;
    if (VALID !== 1'b1 || OP_A !== 8'h5A || OP_B !== 8'h00) begin
      errors++;
      $display("FAIL reset_restart: valid=%b a=%h b=%h expected 1 5a 00", VALID, OP_A, OP_B);
    end
    READY = 1'b1;
    step();
    READY = 1'b0;
  endtask

  task automatic test_full();
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
    COUNT = 3'd4; UNARY = 1'b0; START = 1'b1;
    step();
    checks++;
    if (RD_ADDR !== 2'd3) begin
      errors++;
      $display("FAIL full_addr_top: addr=%0d expected 3", RD_ADDR);
    end
    // A unary request while busy must be ignored.
    START = 1'b1; UNARY = 1'b1; COUNT = 3'd1;
    step();
    START = 1'b0; UNARY = 1'b0; COUNT = 3'd4;
    checks++;
    if (RD_ADDR !== 2'd2 || OP_B !== 8'd4) begin
      errors++;
      $display("FAIL full_addr_next: addr=%0d b=%0d expected 2 4", RD_ADDR, OP_B);
    end
    step();
    checks++;
    if (VALID !== 1'b1 || OP_A !== 8'd3 || OP_B !== 8'd4) begin
      errors++;
      $display("FAIL full_present: valid=%b a=%0d b=%0d expected 1 3 4", VALID, OP_A, OP_B);
    end
    READY = 1'b1;
    #1;
    checks++;
    if (POP !== 1'b1 || POP_N !== 2'd2) begin
      errors++;
      $display("FAIL full_pop: pop=%b pop_n=%0d expected 1 2", POP, POP_N);
    end
    step();
    READY = 1'b0;
    step();
    checks++;
    if (BUSY !== 1'b0 || VALID !== 1'b0 || UNDERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL full_no_queue: busy=%b valid=%b uf=%b expected 0 0 0", BUSY, VALID, UNDERFLOW);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    test_reset();
    test_binary();
    test_unary();
    test_underflow();
    test_hold();
    test_reset_mid();
    test_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
